// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx instance between NUM_REQ byte-stream requesters.
// Round-robin arbitration with packet lock: once a requester is granted it
// owns the transmitter until its byte flagged "last" has been sent.
// The arbiter drives uart_tx through its tx_start / tx_busy handshake.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a locked requester that leaves its valid low in S_HOLD for
//   HOLD_TIMEOUT cycles loses the grant and lock_timeout pulses for one cycle.
//   When undefined, lock_timeout is tied low and the lock is held indefinitely.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   HOLD_TIMEOUT  idle cycles allowed in S_HOLD before forced release
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   req_valid     per-requester byte valid
//   req_data      byte of requester i at [8*i+7:8*i]
//   req_last      byte is the last of its packet
//   req_ready     one-cycle pulse: byte of requester i consumed
//   grant         one-hot current owner, all-zero when unowned
//   tx_start      one-cycle start pulse to uart_tx
//   tx_data       byte to uart_tx, valid while tx_start is high
//   tx_busy       busy flag from uart_tx
//   arb_busy      high whenever the controller is not idle
//   lock_timeout  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 arb_busy,
    output logic                 lock_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_HOLD
    } state_t;

    state_t             state_reg;
    logic [IW-1:0]      ptr_reg;
    logic [IW-1:0]      owner_reg;
    logic               last_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [NUM_REQ-1:0] req_ready_reg;
    logic               tx_start_reg;
    logic [7:0]         tx_data_reg;

    // ------------------------------------------------------------------
    // Round-robin candidate list: candidate k is requester (ptr + k) mod N,
    // so the lowest k with a valid request is the winner.
    // ------------------------------------------------------------------
    logic [IW-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum = {1'b0, ptr_reg} + (IW+1)'(gi);
            // ptr and gi are both below NUM_REQ, so a single subtract wraps
            assign cand_idx[gi] = (sum >= (IW+1)'(NUM_REQ))
                                ? IW'(sum - (IW+1)'(NUM_REQ))
                                : sum[IW-1:0];
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        // Walk downwards so the candidate nearest the pointer wins last
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    logic [NUM_REQ-1:0] pick_onehot;
    logic [7:0]         pick_data;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic [IW-1:0]      ptr_next;

    assign pick_onehot = ONE_HOT0 << pick_idx;
    assign pick_data   = req_data[{pick_idx, 3'b000} +: 8];
    assign owner_valid = req_valid[owner_reg];
    assign owner_last  = req_last[owner_reg];
    assign owner_data  = req_data[{owner_reg, 3'b000} +: 8];
    // Pointer moves just past the releasing owner, wrapping at NUM_REQ-1
    assign ptr_next    = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);
    logic [15:0] hold_cnt_reg;
    logic        lock_timeout_reg;
`else
    // HOLD_TIMEOUT only matters when the timeout is compiled in
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^HOLD_TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // Controller FSM. tx_start / req_ready are registered and high exactly
    // for the single S_SEND cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            last_reg      <= 1'b0;
            grant_reg     <= '0;
            req_ready_reg <= '0;
            tx_start_reg  <= 1'b0;
            tx_data_reg   <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            hold_cnt_reg     <= '0;
            lock_timeout_reg <= 1'b0;
`endif
        end else begin
            tx_start_reg  <= 1'b0;
            req_ready_reg <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            lock_timeout_reg <= 1'b0;
            hold_cnt_reg     <= '0;
`endif
            case (state_reg)
                S_IDLE: begin
                    // Never start while uart_tx is still shifting (e.g. after
                    // a reset that landed mid-frame)
                    if (!tx_busy && pick_found) begin
                        owner_reg     <= pick_idx;
                        grant_reg     <= pick_onehot;
                        tx_data_reg   <= pick_data;
                        tx_start_reg  <= 1'b1;
                        req_ready_reg <= pick_onehot;
                        state_reg     <= S_SEND;
                    end
                end
                S_SEND: begin
                    last_reg  <= owner_last;
                    state_reg <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state_reg <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_reg) begin
                            grant_reg <= '0;
                            ptr_reg   <= ptr_next;
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (owner_valid) begin
                        tx_data_reg   <= owner_data;
                        tx_start_reg  <= 1'b1;
                        req_ready_reg <= grant_reg;
                        state_reg     <= S_SEND;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (hold_cnt_reg == HOLD_LAST) begin
                        grant_reg        <= '0;
                        ptr_reg          <= ptr_next;
                        lock_timeout_reg <= 1'b1;
                        state_reg        <= S_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 16'd1;
                    end
`endif
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign grant     = grant_reg;
    assign tx_start  = tx_start_reg;
    assign tx_data   = tx_data_reg;
    assign arb_busy  = (state_reg != S_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign lock_timeout = lock_timeout_reg;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and HOLD_TIMEOUT=16.
// A behavioural uart_tx stand-in (no reset, 10-bit frame, short bit period)
// answers the tx_start / tx_busy handshake. Each requester is fed from a
// small per-requester byte FIFO; a byte is retired one cycle after its
// req_ready pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int BIT_CYC = 4;
    localparam int FRAME   = 10 * BIT_CYC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        arb_busy;
    logic        lock_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .HOLD_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .arb_busy     (arb_busy),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- uart_tx stand-in (unaffected by rst) ----------------
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    int         starts_on_busy = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) begin
        if (tx_start && m_busy) begin
            starts_on_busy <= starts_on_busy + 1;
        end else if (tx_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_data <= tx_data;
        end else if (m_busy) begin
            if (m_cnt == FRAME - 1) m_busy <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end
    assign tx_busy = m_busy;

    // ---------------- event counters ----------------
    int rdy_cnt [4] = '{0, 0, 0, 0};
    int lt_cnt = 0;

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
        end
        if (lock_timeout) lt_cnt <= lt_cnt + 1;
    end

    // ---------------- requester FIFOs and driver ----------------
    logic [8:0] fifo [4][16];
    int         wr_ptr [4] = '{0, 0, 0, 0};
    int         rd_ptr [4] = '{0, 0, 0, 0};
    logic [3:0] pend = '0;

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                rd_ptr[i] = rd_ptr[i] + 1;
                pend[i]   = 1'b0;
            end
            if (req_ready[i]) pend[i] = 1'b1;
            if (rd_ptr[i] != wr_ptr[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = fifo[i][rd_ptr[i] % 16][7:0];
                req_last[i]        = fifo[i][rd_ptr[i] % 16][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        fifo[r][wr_ptr[r] % 16] = {l, d};
        wr_ptr[r] = wr_ptr[r] + 1;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 2000);
        check({tag, "_start_seen"}, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_busy_fall(input string tag);
        int n;
        n = 0;
        while (!tx_busy && n < 2000) begin tick(); n++; end
        while (tx_busy && n < 2000) begin tick(); n++; end
        check({tag, "_busy_fall_seen"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((arb_busy || tx_busy) && n < 2000) begin tick(); n++; end
        check({tag, "_idle"}, {30'd0, arb_busy, tx_busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int base0, base1, base2, base3, base_lt;

        // Reset values, sampled while reset is held
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_arb_busy", 32'(arb_busy), 32'h0);
        check("rst_lock_timeout", 32'(lock_timeout), 32'h0);
        rst = 1'b0;
        tick();

        // 1: requester 1 sends a three-byte packet
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        wait_start("t1_b0", n);
        check("t1_b0_data", 32'(tx_data), 32'h41);
        check("t1_b0_grant", 32'(grant), 32'b0010);
        check("t1_b0_ready", 32'(req_ready), 32'b0010);
        wait_busy_fall("t1_b0");
        wait_start("t1_b1", n);
        check("t1_gap_cycles", 32'(n), 32'd2);
        check("t1_b1_data", 32'(tx_data), 32'h42);
        check("t1_b1_grant", 32'(grant), 32'b0010);
        wait_start("t1_b2", n);
        check("t1_b2_data", 32'(tx_data), 32'h43);
        check("t1_b2_grant", 32'(grant), 32'b0010);
        wait_idle("t1");
        check("t1_released_grant", 32'(grant), 32'h0);
        check("t1_ready_count", 32'(rdy_cnt[1]), 32'd3);

        // ptr is now 2: requesters 0 and 3 together -> 3 first, then wrap to 0
        push(0, 8'h0A, 1'b1);
        push(3, 8'h3A, 1'b1);
        wait_start("t1p_a", n);
        check("t1p_a_grant", 32'(grant), 32'b1000);
        check("t1p_a_data", 32'(tx_data), 32'h3A);
        wait_start("t1p_b", n);
        check("t1p_b_grant", 32'(grant), 32'b0001);
        check("t1p_b_data", 32'(tx_data), 32'h0A);
        wait_idle("t1p");

        // 2: after reset (ptr=0) requesters 0 and 2 request together
        do_reset();
        base0 = rdy_cnt[0];
        base2 = rdy_cnt[2];
        push(2, 8'h22, 1'b1);
        push(0, 8'h20, 1'b1);
        wait_start("t2_a", n);
        check("t2_a_grant", 32'(grant), 32'b0001);
        check("t2_a_data", 32'(tx_data), 32'h20);
        wait_start("t2_b", n);
        check("t2_b_grant", 32'(grant), 32'b0100);
        check("t2_b_data", 32'(tx_data), 32'h22);
        wait_idle("t2");
        check("t2_ready0_once", 32'(rdy_cnt[0] - base0), 32'd1);
        check("t2_ready2_once", 32'(rdy_cnt[2] - base2), 32'd1);

        // 3: requester 3 locked mid-packet while requester 0 waits
        base0 = rdy_cnt[0];
        base3 = rdy_cnt[3];
        push(3, 8'h30, 1'b0);
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b1);
        wait_start("t3_a", n);
        check("t3_a_grant", 32'(grant), 32'b1000);
        push(0, 8'h0F, 1'b1);
        wait_start("t3_b", n);
        check("t3_b_data", 32'(tx_data), 32'h31);
        check("t3_b_grant", 32'(grant), 32'b1000);
        check("t3_b_no_ready0", 32'(rdy_cnt[0] - base0), 32'd0);
        wait_start("t3_c", n);
        check("t3_c_data", 32'(tx_data), 32'h32);
        check("t3_c_no_ready0", 32'(rdy_cnt[0] - base0), 32'd0);
        wait_start("t3_d", n);
        check("t3_d_grant", 32'(grant), 32'b0001);
        check("t3_d_data", 32'(tx_data), 32'h0F);
        check("t3_ready3_count", 32'(rdy_cnt[3] - base3), 32'd3);
        wait_idle("t3");

        // 4: reset lands during data bit 3 of a frame
        push(1, 8'h55, 1'b1);
        wait_start("t4_a", n);
        n = 0;
        while (!(m_busy && (m_cnt / BIT_CYC) == 4) && n < 2000) begin tick(); n++; end
        rst = 1'b1;
        #1;
        check("t4_rst_grant", 32'(grant), 32'h0);
        check("t4_rst_arb_busy", 32'(arb_busy), 32'h0);
        check("t4_uart_still_busy", 32'(tx_busy), 32'h1);
        tick();
        rst = 1'b0;
        push(0, 8'hA5, 1'b1);
        wait_start("t4_b", n);
        check("t4_b_tx_busy_at_start", 32'(tx_busy), 32'h0);
        check("t4_b_data", 32'(tx_data), 32'hA5);
        check("t4_b_grant", 32'(grant), 32'b0001);
        wait_idle("t4");
        check("t4_starts_on_busy", 32'(starts_on_busy), 32'd0);

        // 5/6: requester 2 sends a non-last byte then goes quiet; 3 waits
        do_reset();
        base3   = rdy_cnt[3];
        base_lt = lt_cnt;
        push(2, 8'h77, 1'b0);
        wait_start("t5_a", n);
        check("t5_a_grant", 32'(grant), 32'b0100);
        push(3, 8'h33, 1'b1);
        wait_busy_fall("t5");
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        do begin
            tick();
            n++;
        end while (!lock_timeout && n < 200);
        check("t5_timeout_cycles", 32'(n), 32'd17);
        check("t5_timeout_grant", 32'(grant), 32'h0);
        tick();
        check("t5_timeout_one_cycle", 32'(lock_timeout), 32'h0);
        wait_start("t5_b", n);
        check("t5_b_grant", 32'(grant), 32'b1000);
        check("t5_b_data", 32'(tx_data), 32'h33);
        wait_idle("t5");
        check("t5_pulse_count", 32'(lt_cnt - base_lt), 32'd1);
`else
        for (int i = 0; i < 60; i++) tick();
        check("t6_grant_held", 32'(grant), 32'b0100);
        check("t6_arb_busy", 32'(arb_busy), 32'h1);
        check("t6_no_timeout", 32'(lt_cnt - base_lt), 32'd0);
        check("t6_no_ready3", 32'(rdy_cnt[3] - base3), 32'd0);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
